pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage RV32I pipeline. Drives the `en` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC update enable. It resolves three conditions:
- load-use hazards, by inserting a single bubble;
- EX-stage jump/branch redirects, by flushing the younger stages;
- multi-cycle data-memory accesses, by freezing the pipe until acknowledged or timed out.

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Stall/flush control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master: pipeline side (drives hazard inputs, receives enables/flushes).
// slave:  controller side.
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        ex_load_reg;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic        mem_req;
   logic        mem_ack;

   logic        pc_en;
   logic        en_if_id;
   logic        en_id_ex;
   logic        en_ex_mem;
   logic        en_mem_wb;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        flush_mem_wb;
   logic        busy;
   logic        err_timeout;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_load_reg, ex_rd, ex_redirect,
             mem_req, mem_ack,
      input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex,
             flush_mem_wb, busy, err_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_load_reg, ex_rd, ex_redirect,
             mem_req, mem_ack,
      output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex,
             flush_mem_wb, busy, err_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage RV32I pipeline.
// Handles boot flushing, memory freezes (with optional timeout), EX redirects
// and load-use bubbles. Performance counters are built only when the macro
// PIPE_HAZ_PERF_EN is defined; otherwise stall_cnt/flush_cnt read as zero.
module pipe_hazard_ctrl #(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned MEM_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {StBoot, StRun, StMemWait} state_e;

   localparam logic [7:0]  BootLast  = 8'(BOOT_CYCLES - 1);
   localparam logic [15:0] WaitLimit = 16'(MEM_TIMEOUT);
   localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);

   state_e      state_q, state_d;
   logic [7:0]  boot_cnt_q, boot_cnt_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic        err_q, err_d;

   logic load_use;
   logic freeze;     // memory stall outputs this cycle
   logic go;         // pipe free to apply redirect / load-use / normal flow
   logic redirect_fire;
   logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
   logic flush_if_id, flush_id_ex, flush_mem_wb;

   // Load-use detection; x0 never creates a dependency.
   always_comb begin
      load_use = hz.ex_load_reg && (hz.ex_rd != 5'd0) &&
                 ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                  (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
   end

   // Next-state logic: boot sequencing, memory freeze and timeout.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      wcnt_d     = wcnt_q;
      err_d      = err_q;
      freeze     = 1'b0;
      go         = 1'b0;
      unique case (state_q)
         StBoot: begin
            boot_cnt_d = boot_cnt_q + 8'd1;
            if (boot_cnt_q == BootLast) state_d = StRun;
         end
         StRun: begin
            if (hz.mem_req && !hz.mem_ack) begin
               freeze  = 1'b1;
               wcnt_d  = 16'd1;
               state_d = StMemWait;
            end else begin
               go = 1'b1;
            end
         end
         StMemWait: begin
            if (hz.mem_ack) begin
               // Ack beats a simultaneous timeout.
               go      = 1'b1;
               state_d = StRun;
            end else if (TimeoutEn && (wcnt_q == WaitLimit)) begin
               err_d   = 1'b1;
               go      = 1'b1;
               state_d = StRun;
            end else begin
               freeze = 1'b1;
               wcnt_d = wcnt_q + 16'd1;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   // Control outputs, combinational from state and hazard inputs.
   always_comb begin
      pc_en         = 1'b0;
      en_if_id      = 1'b0;
      en_id_ex      = 1'b0;
      en_ex_mem     = 1'b0;
      en_mem_wb     = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      flush_mem_wb  = 1'b0;
      redirect_fire = 1'b0;
      if (state_q == StBoot) begin
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_mem_wb = 1'b1;
      end else if (freeze) begin
         flush_mem_wb = 1'b1;
      end else if (go) begin
         if (hz.ex_redirect) begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = 5'b11111;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            redirect_fire = 1'b1;
         end else if (load_use) begin
            // en_id_ex is overridden by the ID/EX flush, which inserts the bubble.
            {en_id_ex, en_ex_mem, en_mem_wb} = 3'b111;
            flush_id_ex = 1'b1;
         end else begin
            {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = 5'b11111;
         end
      end
   end

   // State, counters and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         boot_cnt_q <= 8'd0;
         wcnt_q     <= 16'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
      end
   end

`ifdef PIPE_HAZ_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Saturating performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((state_q != StBoot) && !pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (redirect_fire && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = 32'd0;
   assign hz.flush_cnt = 32'd0;
`endif

   assign hz.pc_en        = pc_en;
   assign hz.en_if_id     = en_if_id;
   assign hz.en_id_ex     = en_id_ex;
   assign hz.en_ex_mem    = en_ex_mem;
   assign hz.en_mem_wb    = en_mem_wb;
   assign hz.flush_if_id  = flush_if_id;
   assign hz.flush_id_ex  = flush_id_ex;
   assign hz.flush_mem_wb = flush_mem_wb;
   assign hz.busy         = (state_q != StRun);
   assign hz.err_timeout  = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized stimulus against a behavioural reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned BOOT = 4;
   localparam int unsigned TO   = 8;
`ifdef PIPE_HAZ_PERF_EN
   localparam bit Perf = 1'b1;
`else
   localparam bit Perf = 1'b0;
`endif

   // Control word packing: {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
   //                        flush_if_id, flush_id_ex, flush_mem_wb}
   localparam logic [7:0] CtlBoot  = 8'h07;
   localparam logic [7:0] CtlRun   = 8'hF8;
   localparam logic [7:0] CtlRedir = 8'hFE;
   localparam logic [7:0] CtlLoadU = 8'h3A;
   localparam logic [7:0] CtlMem   = 8'h01;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(
      .BOOT_CYCLES (BOOT),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ctl_now();
      return {hz.pc_en, hz.en_if_id, hz.en_id_ex, hz.en_ex_mem, hz.en_mem_wb,
              hz.flush_if_id, hz.flush_id_ex, hz.flush_mem_wb};
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] ctl;
      logic       freeze;
      logic       redir;
      logic       to_rel;
   } ev_t;

   bit          m_in_boot;
   int          m_boot_edges;
   bit          m_frozen;
   int          m_waited;
   bit          m_err;
   longint      m_stall;
   longint      m_flush;
   ev_t         ev;

   function automatic ev_t model_eval(input bit in_boot, input bit frozen, input int waited,
                                      input logic mreq, input logic mack, input logic redir,
                                      input logic load, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic u1, input logic u2);
      ev_t e;
      bit  dep;
      e = '0;
      if (in_boot) begin
         e.ctl = CtlBoot;
      end else begin
         if (frozen) begin
            if (!mack && waited == int'(TO)) e.to_rel = 1'b1;
            else if (!mack)                  e.freeze = 1'b1;
         end else if (mreq && !mack) begin
            e.freeze = 1'b1;
         end
         dep = load && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         if (e.freeze)   e.ctl = CtlMem;
         else if (redir) begin e.ctl = CtlRedir; e.redir = 1'b1; end
         else if (dep)   e.ctl = CtlLoadU;
         else            e.ctl = CtlRun;
      end
      return e;
   endfunction

   always_comb ev = model_eval(m_in_boot, m_frozen, m_waited, hz.mem_req, hz.mem_ack,
                               hz.ex_redirect, hz.ex_load_reg, hz.ex_rd, hz.id_rs1,
                               hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_in_boot    <= 1'b1;
         m_boot_edges <= 0;
         m_frozen     <= 1'b0;
         m_waited     <= 0;
         m_err        <= 1'b0;
         m_stall      <= 0;
         m_flush      <= 0;
      end else if (m_in_boot) begin
         m_boot_edges <= m_boot_edges + 1;
         if (m_boot_edges + 1 == int'(BOOT)) m_in_boot <= 1'b0;
      end else begin
         m_frozen <= ev.freeze;
         if (ev.freeze) m_waited <= m_frozen ? m_waited + 1 : 1;
         if (ev.to_rel) m_err <= 1'b1;
         if (!ev.ctl[7]) m_stall <= m_stall + 1;
         if (ev.redir)   m_flush <= m_flush + 1;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       load;
      logic [4:0] rd;
      logic       redir;
      logic [7:0] exp_ctl;
   } vec_t;

   vec_t vecs[8];

   task automatic clear_inputs();
      hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
      hz.ex_load_reg = 0; hz.ex_rd = 0; hz.ex_redirect = 0;
      hz.mem_req = 0; hz.mem_ack = 0;
   endtask

   task automatic boot_run(input string tag);
      for (int k = 1; k <= int'(BOOT); k++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s_busy_e%0d", tag, k), hz.busy, (k < int'(BOOT)));
         check($sformatf("%s_ctl_e%0d", tag, k), ctl_now(), (k < int'(BOOT)) ? CtlBoot : CtlRun);
      end
   endtask

   logic [31:0] s0, f0;

   initial begin
      vecs[0] = '{0, 0, 0, 0, 0, 0, 0, CtlRun};
      vecs[1] = '{0, 5, 0, 1, 1, 5, 0, CtlLoadU};
      vecs[2] = '{0, 0, 0, 1, 1, 0, 0, CtlRun};     // rd=x0: no stall
      vecs[3] = '{7, 3, 1, 0, 1, 7, 0, CtlLoadU};
      vecs[4] = '{7, 3, 0, 1, 1, 7, 0, CtlRun};     // rs1 matches but unused
      vecs[5] = '{9, 9, 1, 1, 0, 9, 0, CtlRun};     // not a load
      vecs[6] = '{0, 0, 0, 0, 0, 0, 1, CtlRedir};
      vecs[7] = '{0, 5, 0, 1, 1, 5, 1, CtlRedir};   // redirect beats load-use

      clear_inputs();
      #2 rst_n = 1'b0;
      #20;
      check("rst_ctl", ctl_now(), CtlBoot);
      check("rst_busy", hz.busy, 1'b1);
      check("rst_err", hz.err_timeout, 1'b0);
      check("rst_stall_cnt", hz.stall_cnt, 0);
      check("rst_flush_cnt", hz.flush_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      boot_run("boot");

      // Table vectors in RUN.
      foreach (vecs[i]) begin
         @(negedge clk);
         clear_inputs();
         hz.id_rs1 = vecs[i].rs1; hz.id_rs2 = vecs[i].rs2;
         hz.id_use_rs1 = vecs[i].u1; hz.id_use_rs2 = vecs[i].u2;
         hz.ex_load_reg = vecs[i].load; hz.ex_rd = vecs[i].rd;
         hz.ex_redirect = vecs[i].redir;
         #1;
         check($sformatf("vec%0d_ctl", i), ctl_now(), vecs[i].exp_ctl);
      end

      // Memory freeze of 3 cycles with a redirect pending throughout.
      @(negedge clk);
      clear_inputs();
      #1;
      s0 = hz.stall_cnt; f0 = hz.flush_cnt;
      @(negedge clk);
      hz.mem_req = 1; hz.ex_redirect = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("memw_ctl_c%0d", c), ctl_now(), CtlMem);
         check($sformatf("memw_busy_c%0d", c), hz.busy, (c != 0));
         @(negedge clk);
      end
      hz.mem_ack = 1;
      #1;
      check("memw_release_ctl", ctl_now(), CtlRedir);
      check("memw_release_busy", hz.busy, 1'b1);
      @(negedge clk);
      clear_inputs();
      #1;
      check("memw_after_ctl", ctl_now(), CtlRun);
      check("memw_after_busy", hz.busy, 1'b0);
      check("memw_stall_delta", hz.stall_cnt - s0, Perf ? 3 : 0);
      check("memw_flush_delta", hz.flush_cnt - f0, Perf ? 1 : 0);

      // Timeout: no ack ever.
      @(negedge clk);
      hz.mem_req = 1;
      for (int c = 0; c < int'(TO); c++) begin
         #1;
         check($sformatf("to_ctl_c%0d", c), ctl_now(), CtlMem);
         check($sformatf("to_err_c%0d", c), hz.err_timeout, 1'b0);
         @(negedge clk);
      end
      #1;
      check("to_release_ctl", ctl_now(), CtlRun);
      check("to_release_busy", hz.busy, 1'b1);
      @(negedge clk);
      hz.mem_req = 0;
      #1;
      check("to_err_set", hz.err_timeout, 1'b1);
      check("to_busy_after", hz.busy, 1'b0);

      // Reset asserted while frozen.
      @(negedge clk);
      hz.mem_req = 1;
      repeat (3) @(negedge clk);
      #1;
      check("rstw_busy_before", hz.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstw_ctl", ctl_now(), CtlBoot);
      check("rstw_busy", hz.busy, 1'b1);
      check("rstw_err", hz.err_timeout, 1'b0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      boot_run("reboot");

      // Ack arriving exactly at the timeout count wins.
      @(negedge clk);
      hz.mem_req = 1;
      repeat (int'(TO)) @(negedge clk);
      hz.mem_ack = 1;
      #1;
      check("ackto_ctl", ctl_now(), CtlRun);
      @(negedge clk);
      clear_inputs();
      #1;
      check("ackto_err", hz.err_timeout, 1'b0);
      check("ackto_busy", hz.busy, 1'b0);

      // Randomized run against the reference model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         hz.id_rs1      = 5'($urandom_range(0, 3));
         hz.id_rs2      = 5'($urandom_range(0, 3));
         hz.ex_rd       = 5'($urandom_range(0, 3));
         hz.id_use_rs1  = 1'($urandom_range(0, 1));
         hz.id_use_rs2  = 1'($urandom_range(0, 1));
         hz.ex_load_reg = 1'($urandom_range(0, 1));
         hz.ex_redirect = ($urandom_range(0, 4) == 0);
         hz.mem_req     = ($urandom_range(0, 3) == 0);
         hz.mem_ack     = m_frozen ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 4) < 2);
         if (i % 1000 == 999) begin
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         #1;
         check($sformatf("rnd%0d_ctl", i), ctl_now(), ev.ctl);
         check($sformatf("rnd%0d_busy", i), hz.busy, m_in_boot || m_frozen);
         check($sformatf("rnd%0d_err", i), hz.err_timeout, m_err);
         check($sformatf("rnd%0d_stall_cnt", i), hz.stall_cnt, Perf ? m_stall : 0);
         check($sformatf("rnd%0d_flush_cnt", i), hz.flush_cnt, Perf ? m_flush : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
